// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation mode encodings and the sequencer state type
// used by the digit-serial adder/subtractor.
package alu_pkg;

    localparam logic [1:0] MODE_ADD     = 2'b00;
    localparam logic [1:0] MODE_SUB     = 2'b01;
    localparam logic [1:0] MODE_ACC_ADD = 2'b10;
    localparam logic [1:0] MODE_ACC_SUB = 2'b11;

    // mode[0] selects subtract, mode[1] takes operand A from the accumulator.
    localparam int MODE_SUB_BIT = 0;
    localparam int MODE_ACC_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage : alu_pkg

// File: rtl/add_sub_digit.sv
// Combinational W-bit digit adder. Besides the carry out it reports the carry
// into the digit MSB, which the caller needs for signed-overflow detection.
module add_sub_digit #(
    parameter int W = 4
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         c_msb
);

    logic [W:0] w_full;

    assign w_full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
    assign sum    = w_full[W-1:0];
    assign cout   = w_full[W];
    // The MSB sum bit is x^y^carry_in, so the carry into the MSB falls out by
    // XOR-ing the operand bits back off; this holds for any W including 1.
    assign c_msb  = w_full[W-1] ^ x[W-1] ^ y[W-1];

endmodule : add_sub_digit

// File: rtl/add_sub_seq.sv
// Digit-serial N-bit adder/subtractor: W bits per cycle from the LSB, with an
// accumulator for chained operations and a start/ready/done handshake.
module add_sub_seq
    import alu_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   mode,
    input  logic         acc_clr,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         ovf,
    output logic         zero
);

    localparam int D  = N / W;
    localparam int CW = (D > 1) ? $clog2(D) : 1;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(D - 1);

    generate
        if ((N % W) != 0 || W < 1) begin : g_bad_digit_width
            $error("add_sub_seq: N must be a non-zero multiple of W");
        end
    endgenerate

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N-1:0]    r_opa;
    logic [N-1:0]    r_opb;
    logic [N-1:0]    r_res;
    logic [N-1:0]    r_acc;
    logic [N-1:0]    r_s;
    logic [CW-1:0]   r_cnt;
    logic            r_carry;
    logic            r_cout;
    logic            r_ovf;
    logic            r_zero;

    logic            w_sub;
    logic            w_acc_en;
    logic            w_last;
    logic [N-1:0]    w_opa_sel;
    logic [N-1:0]    w_opb_sel;
    logic [N-1:0]    w_res_nxt;
    logic [W-1:0]    w_sum;
    logic            w_dcout;
    logic            w_cmsb;

    assign w_sub    = mode[MODE_SUB_BIT];
    assign w_acc_en = mode[MODE_ACC_BIT];
    assign w_last   = (r_cnt == LAST_DIGIT);

    // A clear issued together with start wins over the stale accumulator value.
    assign w_opa_sel = w_acc_en ? (acc_clr ? '0 : r_acc) : a;
    // Subtraction is A + ~B + 1; the +1 enters through the initial carry.
    assign w_opb_sel = w_sub ? ~b : b;

    // New digit enters at the top so after D shifts the LSB digit sits at bit 0.
    assign w_res_nxt = (r_res >> W) | (N'(w_sum) << (N - W));

    add_sub_digit #(
        .W (W)
    ) u_digit (
        .x     (r_opa[W-1:0]),
        .y     (r_opb[W-1:0]),
        .cin   (r_carry),
        .sum   (w_sum),
        .cout  (w_dcout),
        .c_msb (w_cmsb)
    );

    // NOTE: every sequential block uses non-blocking (<=) so all registers see
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: the default assignment first guarantees no path leaves w_state_nxt
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (start)  w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
            ST_DONE:             w_state_nxt = ST_IDLE;
            default:             w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: the datapath is a handful of registers, not a memory array, so every
    // one of them is reset; reset must clear acc, s and the flags mid-operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opa   <= '0;
            r_opb   <= '0;
            r_res   <= '0;
            r_acc   <= '0;
            r_s     <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (acc_clr) begin
                        r_acc <= '0;
                    end
                    if (start) begin
                        r_opa   <= w_opa_sel;
                        r_opb   <= w_opb_sel;
                        r_carry <= w_sub;
                        r_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    r_opa   <= r_opa >> W;
                    r_opb   <= r_opb >> W;
                    r_res   <= w_res_nxt;
                    r_carry <= w_dcout;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_s    <= w_res_nxt;
                        r_cout <= w_dcout;
                        r_ovf  <= w_dcout ^ w_cmsb;
                        r_zero <= (w_res_nxt == '0);
                    end
                end
                ST_DONE: begin
                    r_acc <= r_s;
                end
                default: ;
            endcase
        end
    end

    assign ready = (r_state == ST_IDLE);
    assign done  = (r_state == ST_DONE);
    assign s     = r_s;
    assign cout  = r_cout;
    assign ovf   = r_ovf;
    assign zero  = r_zero;

endmodule : add_sub_seq

// File: tb/tb_add_sub_seq.sv
// Self-checking bench for add_sub_seq (N=8, W=4): directed scenarios followed by
// random operations, all compared against a plain-arithmetic reference model.
module tb_add_sub_seq;
    import alu_pkg::*;

    localparam int N = 8;
    localparam int W = 4;
    localparam int D = N / W;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [1:0]   mode;
    logic         acc_clr;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         ready;
    logic         done;
    logic [N-1:0] s;
    logic         cout;
    logic         ovf;
    logic         zero;

    int           checks;
    int           errors;
    logic [N-1:0] acc_m;

    add_sub_seq #(
        .N (N),
        .W (W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .mode    (mode),
        .acc_clr (acc_clr),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .done    (done),
        .s       (s),
        .cout    (cout),
        .ovf     (ovf),
        .zero    (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation did not complete");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_acc();
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        acc_m   = '0;
    endtask

    // One operation through the handshake; poke keeps start high and scrambles
    // the other inputs while the operation is in flight.
    task automatic run_op(input logic [1:0] m, input logic [N-1:0] av,
                          input logic [N-1:0] bv, input logic clr, input logic poke);
        int           opa;
        int           opb;
        int           sa;
        int           sb;
        int           r;
        int           sr;
        int           waited;
        int           edges;
        logic [N-1:0] exp_s;
        logic         exp_cout;
        logic         exp_ovf;
        logic [N-1:0] s_before;

        opa = m[MODE_ACC_BIT] ? (clr ? 0 : int'(acc_m)) : int'(av);
        opb = int'(bv);
        sa  = (opa > 127) ? opa - 256 : opa;
        sb  = (opb > 127) ? opb - 256 : opb;
        if (m[MODE_SUB_BIT]) begin
            r        = opa - opb;
            sr       = sa - sb;
            exp_cout = (opa >= opb);
        end else begin
            r        = opa + opb;
            sr       = sa + sb;
            exp_cout = (r > 255);
        end
        exp_s   = N'(r & 255);
        exp_ovf = (sr > 127) || (sr < -128);

        waited = 0;
        while (!ready && waited < 20) begin
            tick();
            waited++;
        end
        check("ready_before_start", 32'(ready), 32'd1);

        s_before = s;
        start    = 1'b1;
        mode     = m;
        a        = av;
        b        = bv;
        acc_clr  = clr;
        tick();
        acc_clr = 1'b0;
        if (poke) begin
            a       = N'($urandom);
            b       = N'($urandom);
            mode    = 2'($urandom);
            acc_clr = 1'($urandom);
        end else begin
            start = 1'b0;
        end
        check("ready_fall", 32'(ready), 32'd0);

        edges = 0;
        while (!done && edges < 20) begin
            check("s_hold_during_run", 32'(s), 32'(s_before));
            tick();
            edges++;
        end
        // done appears right after the D-th RUN edge following the start edge.
        check("done_latency", 32'(edges), 32'(D));
        check("s", 32'(s), 32'(exp_s));
        check("cout", 32'(cout), 32'(exp_cout));
        check("ovf", 32'(ovf), 32'(exp_ovf));
        check("zero", 32'(zero), 32'(exp_s == '0));
        acc_m = exp_s;

        tick();
        start   = 1'b0;
        acc_clr = 1'b0;
        check("done_pulse_end", 32'(done), 32'd0);
        check("ready_return", 32'(ready), 32'd1);
        if (poke) begin
            for (int i = 0; i < 3; i++) begin
                tick();
                check("no_extra_done", 32'(done), 32'd0);
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        acc_m   = '0;
        rst_n   = 1'b0;
        start   = 1'b0;
        mode    = MODE_ADD;
        acc_clr = 1'b0;
        a       = '0;
        b       = '0;

        // 1. reset values, then the all-zero add
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_s", 32'(s), 32'd0);
        check("rst_flags", {29'd0, cout, ovf, zero}, 32'd0);
        run_op(MODE_ADD, 8'h00, 8'h00, 1'b0, 1'b0);

        // 2. unsigned wrap to zero, signed overflow on add
        run_op(MODE_ADD, 8'hF0, 8'h10, 1'b0, 1'b0);
        run_op(MODE_ADD, 8'h7F, 8'h01, 1'b0, 1'b0);

        // 3. borrow and signed overflow on subtract
        run_op(MODE_SUB, 8'h05, 8'h07, 1'b0, 1'b0);
        run_op(MODE_SUB, 8'h80, 8'h01, 1'b0, 1'b0);

        // 4. accumulate chain; operand a is ignored
        clear_acc();
        for (int i = 0; i < 3; i++) begin
            run_op(MODE_ACC_ADD, N'($urandom), 8'h03, 1'b0, 1'b0);
        end
        check("acc_chain", 32'(acc_m), 32'h09);
        run_op(MODE_ACC_SUB, N'($urandom), 8'h09, 1'b0, 1'b0);

        // 5. start held through RUN/DONE, then clear together with start
        run_op(MODE_ADD, 8'h12, 8'h34, 1'b0, 1'b1);
        run_op(MODE_ACC_ADD, 8'hAA, 8'h22, 1'b0, 1'b0);
        run_op(MODE_ACC_ADD, 8'hAA, 8'h05, 1'b1, 1'b0);

        // 6. reset in the middle of RUN
        start = 1'b1;
        mode  = MODE_ADD;
        a     = 8'h21;
        b     = 8'h43;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_s", 32'(s), 32'd0);
        check("midrst_flags", {29'd0, cout, ovf, zero}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst_no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        acc_m = '0;
        tick();
        check("midrst_no_done_after", 32'(done), 32'd0);
        run_op(MODE_ACC_ADD, N'($urandom), 8'h01, 1'b0, 1'b0);

        // randomized operations across all modes
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                clear_acc();
            end
            run_op(2'($urandom_range(0, 3)), N'($urandom), N'($urandom),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_add_sub_seq
